cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Phase sequencer and control decoder for the 5-bit-address accumulator CPU. It steps every instruction through a fixed 8-phase cycle, drives the bus select and memory strobes, and issues the `inc_pc`/`ld_pc` commands to the program counter. It also drives the load strobes for the instruction register and the accumulator. It sits directly upstream of the program counter, and its `ld_pc` feeds the PC's `load` input.

## Interface
Parameters: none; the opcode width (3) and phase count (8) are fixed by the ISA.

Ports:
- `clk`  in  1  system clock, all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  3  instruction register bits [7:5]; valid from phase IDLE onward
- `zero`  in  1  accumulator-is-zero flag, sampled combinationally in ALU_OP
- `sel`  out  1  address mux select: 1 = PC address, 0 = IR operand address
- `rd`  out  1  memory read strobe
- `wr`  out  1  memory write strobe
- `ld_ir`  out  1  instruction register load
- `ld_ac`  out  1  accumulator load
- `inc_pc`  out  1  PC advance command
- `ld_pc`  out  1  PC parallel load (jump); drives the PC `load` input
- `data_e`  out  1  accumulator-to-data-bus output enable
- `halt`  out  1  CPU halted
- `phase`  out  3  current phase, for debug and bench

## Operation
Opcodes:
- HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP = ADD | AND | XOR | LDA.

State:
- A 3-bit phase register with states INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7).
- A 1-bit halted flag.
- The phase advances by +1 every cycle and wraps 7→0.

Outputs are combinational from the phase, `opcode`, `zero` and the halted flag. Any output not listed for a phase is 0.
- INST_ADDR: sel.
- INST_FETCH: sel, rd.
- INST_LOAD: sel, rd, ld_ir.
- IDLE: sel, rd, ld_ir.
- OP_ADDR: inc_pc; halt = (opcode==HLT).
- OP_FETCH: rd = ALUOP.
- ALU_OP: rd = ALUOP; inc_pc = (opcode==SKZ) & zero; ld_pc = JMP; data_e = STO.
- STORE: rd = ALUOP; ld_ac = ALUOP; inc_pc = JMP; ld_pc = JMP; wr = STO; data_e = STO.

Halt behaviour:
- In OP_ADDR with opcode==HLT, the halted flag sets on the next edge and the phase stays at OP_ADDR.
- While halted:
  - Phase is frozen at 4.
  - halt=1.
  - Every other output is 0, including inc_pc. The PC therefore does not advance past the HLT instruction twice.
- Only `rst` leaves halt.

Reset:
- `rst` asserted, asynchronously: phase=INST_ADDR and halted=0.
- Output values in reset: sel=1, all other outputs 0, phase=0.
- Reset mid-instruction abandons that instruction. No wr pulse may occur after `rst` rises.

## Timing
- One instruction takes exactly 8 cycles. The first edge after `rst` deasserts moves the phase 0→1.
- `inc_pc` is a single-cycle pulse in OP_ADDR for every non-HLT instruction. Pulse count per instruction:
  - SKZ with zero=1: one extra pulse in ALU_OP, 2 total.
  - JMP: one extra pulse in STORE, coincident with ld_pc.
- `ld_pc` is high for exactly the two cycles ALU_OP and STORE, and only for JMP.
- `wr` is high in STORE only, one cycle, STO only. `data_e` is high in ALU_OP and STORE so data is stable before and during `wr`.
- `opcode` changes during INST_LOAD/IDLE must not affect outputs in those phases; only phases 4–7 depend on opcode.
- `zero` is only used in ALU_OP. A change of `zero` in any other phase has no effect.

## Test plan
- Reset: assert `rst` mid-phase 6 with opcode=STO. Required: phase=0, sel=1, and wr/data_e/ld_pc/inc_pc/halt all 0 immediately, with no clock edge needed. Release `rst`: phase steps 1,2,…,7,0.
- ADD (010) sequence: per phase 0..7, sel=1,1,1,1,0,0,0,0. rd=0,1,1,1,0,1,1,1. ld_ir high only in phases 2–3. inc_pc high only in phase 4. ld_ac high only in phase 7.
- SKZ (001): with zero=1, inc_pc pulses in phases 4 and 6 (2 pulses). With zero=0, it pulses only in phase 4. rd=0 in phases 5–7 in both cases.
- JMP (111): ld_pc=1 in phases 6–7, and inc_pc=1 in phases 4 and 7. STO (110): data_e=1 in phases 6–7, wr=1 in phase 7 only, and rd=0 in phases 5–7.
- HLT (000): halt=1 in phase 4, then phase holds at 4 for 20+ cycles with halt=1 and inc_pc=0. Changing opcode to ADD while halted has no effect. `rst` clears halt and sets phase=0.
- Back-to-back: run 4 instructions (LDA, XOR, SKZ with zero=0, JMP). Required: 32 cycles with phase wrapping 7→0 each time, and exactly 5 inc_pc pulses and 2 ld_pc cycles in total.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer and control decoder for the 5-bit-address accumulator CPU.
// Outputs are combinational from phase, opcode, zero and the halted flag; halt freezes the phase at OP_ADDR.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  phase_t r_phase;
  phase_t w_phase_nxt;
  logic   r_halted;
  logic   w_halted_nxt;
  logic   w_aluop;
  logic   w_hlt;
  logic   w_sto;
  logic   w_jmp;

  assign w_aluop = (opcode == OP_ADD) | (opcode == OP_AND) | (opcode == OP_XOR) | (opcode == OP_LDA);
  assign w_hlt   = (opcode == OP_HLT);
  assign w_sto   = (opcode == OP_STO);
  assign w_jmp   = (opcode == OP_JMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // A HLT seen in OP_ADDR parks the phase there until reset.
  always_comb begin
    w_halted_nxt = r_halted;
    w_phase_nxt  = phase_t'(r_phase + 3'd1);
    if (r_halted) begin
      w_phase_nxt = OP_ADDR;
    end else if ((r_phase == OP_ADDR) && w_hlt) begin
      w_halted_nxt = 1'b1;
      w_phase_nxt  = OP_ADDR;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (r_halted) begin
      halt = 1'b1;
    end else begin
      case (r_phase)
        INST_ADDR: sel = 1'b1;
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = w_hlt;
        end
        OP_FETCH: rd = w_aluop;
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == OP_SKZ) & zero;
          ld_pc  = w_jmp;
          data_e = w_sto;
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          inc_pc = w_jmp;
          ld_pc  = w_jmp;
          wr     = w_sto;
          data_e = w_sto;
        end
        default: ;
      endcase
    end
  end

  assign phase = r_phase;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase output vectors for each opcode class, reset, halt and a short program.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .inc_pc(inc_pc), .ld_pc(ld_pc), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  // {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt}
  logic [8:0] obs;
  assign obs = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = STO; zero = 1'b0;
    tick(); tick();
    checks++;
    if (phase !== 3'd0 || obs !== 9'h100) begin
      errors++; $display("FAIL reset_state: phase=%0d outs=%h, want phase=0 outs=100", phase, obs);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    checks++;
    if (phase !== 3'd6 || obs !== 9'h002) begin
      errors++; $display("FAIL sto_phase6_pre_reset: phase=%0d outs=%h, want phase=6 outs=002", phase, obs);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd0 || obs !== 9'h100) begin
      errors++; $display("FAIL async_reset: phase=%0d outs=%h, want phase=0 outs=100", phase, obs);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (phase !== 3'd0 || wr !== 1'b0 || sel !== 1'b1) begin
        errors++; $display("FAIL reset_hold: phase=%0d wr=%b sel=%b, want phase=0 wr=0 sel=1", phase, wr, sel);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (phase !== 3'(k % 8)) begin
        errors++; $display("FAIL reset_release_step: phase=%0d, want %0d", phase, k % 8);
      end
    end
  endtask

  task automatic test_add();
    logic [8:0] tab [8];
    tab = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h008, 9'h080, 9'h080, 9'h090};
    for (int p = 0; p < 8; p++) begin
      // opcode churn before OP_ADDR must not show on the fetch-phase outputs
      opcode = (p < 4) ? ((p % 2 == 0) ? HLT : JMP) : ADD;
      zero = p[0];
      #1;
      checks++;
      if (phase !== 3'(p) || obs !== tab[p]) begin
        errors++; $display("FAIL add_phase%0d: phase=%0d outs=%h, want outs=%h", p, phase, obs, tab[p]);
      end
      tick();
    end
  endtask

  task automatic test_skz();
    logic [8:0] tab [8];
    for (int z = 1; z >= 0; z--) begin
      tab = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h008, 9'h000, (z == 1) ? 9'h008 : 9'h000, 9'h000};
      opcode = SKZ;
      for (int p = 0; p < 8; p++) begin
        zero = (p == 6) ? z[0] : ~z[0];
        #1;
        checks++;
        if (phase !== 3'(p) || obs !== tab[p]) begin
          errors++; $display("FAIL skz_z%0d_phase%0d: phase=%0d outs=%h, want outs=%h", z, p, phase, obs, tab[p]);
        end
        tick();
      end
    end
  endtask

  task automatic test_jmp_sto();
    logic [8:0] tab_j [8];
    logic [8:0] tab_s [8];
    tab_j = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h008, 9'h000, 9'h004, 9'h00C};
    tab_s = '{9'h100, 9'h180, 9'h1A0, 9'h1A0, 9'h008, 9'h000, 9'h002, 9'h042};
    opcode = JMP; zero = 1'b1;
    for (int p = 0; p < 8; p++) begin
      #1;
      checks++;
      if (phase !== 3'(p) || obs !== tab_j[p]) begin
        errors++; $display("FAIL jmp_phase%0d: phase=%0d outs=%h, want outs=%h", p, phase, obs, tab_j[p]);
      end
      tick();
    end
    opcode = STO; zero = 1'b0;
    for (int p = 0; p < 8; p++) begin
      #1;
      checks++;
      if (phase !== 3'(p) || obs !== tab_s[p]) begin
        errors++; $display("FAIL sto_phase%0d: phase=%0d outs=%h, want outs=%h", p, phase, obs, tab_s[p]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] prog [4];
    int n_inc = 0, n_ld = 0, bad_phase = 0;
    prog = '{LDA, XOR_, SKZ, JMP};
    zero = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c % 8 == 0) opcode = prog[c / 8];
      #1;
      if (phase !== 3'(c % 8)) bad_phase++;
      if (inc_pc === 1'b1) n_inc++;
      if (ld_pc === 1'b1) n_ld++;
      tick();
    end
    checks++;
    if (bad_phase !== 0 || phase !== 3'd0) begin
      errors++; $display("FAIL b2b_phase_wrap: %0d bad phases, end phase=%0d, want 0 and 0", bad_phase, phase);
    end
    checks++;
    if (n_inc !== 5) begin
      errors++; $display("FAIL b2b_inc_pc_count: got %0d, want 5", n_inc);
    end
    checks++;
    if (n_ld !== 2) begin
      errors++; $display("FAIL b2b_ld_pc_count: got %0d, want 2", n_ld);
    end
  endtask

  task automatic test_halt();
    opcode = HLT; zero = 1'b1;
    for (int p = 0; p < 4; p++) tick();
    checks++;
    if (phase !== 3'd4 || halt !== 1'b1 || rd !== 1'b0 || wr !== 1'b0) begin
      errors++; $display("FAIL halt_enter: phase=%0d halt=%b rd=%b wr=%b, want 4 1 0 0", phase, halt, rd, wr);
    end
    for (int k = 0; k < 22; k++) begin
      tick();
      if (k == 5) opcode = ADD;
      #1;
      checks++;
      if (phase !== 3'd4 || obs !== 9'h001) begin
        errors++; $display("FAIL halt_hold_%0d: phase=%0d outs=%h, want phase=4 outs=001", k, phase, obs);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd0 || obs !== 9'h100) begin
      errors++; $display("FAIL halt_reset: phase=%0d outs=%h, want phase=0 outs=100", phase, obs);
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (phase !== 3'd1 || halt !== 1'b0) begin
      errors++; $display("FAIL halt_restart: phase=%0d halt=%b, want 1 0", phase, halt);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = HLT; zero = 1'b0;
    test_reset();
    test_add();
    test_skz();
    test_jmp_sto();
    test_back_to_back();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
